// File: rtl/sr_ff_bank.sv
// sr_ff_bank: multi-channel SR flip-flop bank with 2-flop button synchronisers and optional debounce.
// Define SR_FF_BANK_DEBOUNCE_EN to build the per-input debounce stage.
module sr_ff_bank #(
    parameter int                     CHANNELS        = 4,
    parameter int                     DEBOUNCE_CYCLES = 16,
    parameter bit                     SET_DOMINANT    = 1'b0,
    parameter logic [CHANNELS-1:0]    INIT            = '0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] BUT_S,
    input  logic [CHANNELS-1:0] BUT_R,
    output logic [CHANNELS-1:0] LED_Q,
    output logic [CHANNELS-1:0] LED_NQ,
    output logic [CHANNELS-1:0] CHANGED
);
    localparam int N = 2 * CHANNELS;

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("sr_ff_bank: CHANNELS and DEBOUNCE_CYCLES must be >= 1");
    end

    // Set buttons occupy the low half, reset buttons the high half.
    logic [N-1:0]        sync1_q, sync2_q, lvl;
    logic [CHANNELS-1:0] q_q, q_d, chg_q, s, r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {BUT_R, BUT_S};
            sync2_q <= sync1_q;
        end
    end

`ifdef SR_FF_BANK_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]         deb_q, deb_d;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == LAST) deb_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = deb_q;
`else
    assign lvl = sync2_q;
`endif

    assign s = lvl[CHANNELS-1:0];
    assign r = lvl[N-1:CHANNELS];

    // s&r resolves to SET_DOMINANT; neither button pressed holds.
    always_comb q_d = (s & (~r | {CHANNELS{SET_DOMINANT}})) | (~s & ~r & q_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q   <= INIT;
            chg_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= q_d ^ q_q;
        end
    end

    assign LED_Q   = q_q;
    assign LED_NQ  = ~q_q;
    assign CHANGED = chg_q;
endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: directed stimulus with a scoreboard of expected CHANGED events checked by a monitor.
module tb_sr_ff_bank;
`ifdef SR_FF_BANK_DEBOUNCE_EN
    localparam bit DB = 1'b1;
    localparam int L  = 6;
`else
    localparam bit DB = 1'b0;
    localparam int L  = 2;
`endif

    typedef struct {
        int         c;
        logic [3:0] q;
        logic [3:0] ch;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [3:0] BUT_S = '0, BUT_R = '0;
    logic [3:0] LED_Q, LED_NQ, CHANGED;
    logic [3:0] sd_q, sd_nq, sd_chg;
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    exp_t       sb[$];

    sr_ff_bank #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .SET_DOMINANT(1'b0), .INIT(4'b0000)) dut (
        .CLK(CLK), .RST_N(RST_N), .BUT_S(BUT_S), .BUT_R(BUT_R),
        .LED_Q(LED_Q), .LED_NQ(LED_NQ), .CHANGED(CHANGED)
    );

    sr_ff_bank #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .SET_DOMINANT(1'b1), .INIT(4'b1010)) dut_sd (
        .CLK(CLK), .RST_N(RST_N), .BUT_S(BUT_S), .BUT_R(BUT_R),
        .LED_Q(sd_q), .LED_NQ(sd_nq), .CHANGED(sd_chg)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST_N && CHANGED != 4'b0000) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse: cyc=%0d CHANGED=%b LED_Q=%b", cyc, CHANGED, LED_Q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.c != cyc || e.q !== LED_Q || e.ch !== CHANGED || LED_NQ !== ~LED_Q) begin
                    mismatched++;
                    $display("FAIL event: got cyc=%0d Q=%b NQ=%b CH=%b, want cyc=%0d Q=%b NQ=%b CH=%b",
                             cyc, LED_Q, LED_NQ, CHANGED, e.c, e.q, ~e.q, e.ch);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [3:0] r);
        @(posedge CLK);
        #2;
        BUT_S = s;
        BUT_R = r;
    endtask

    task automatic push(input int c, input logic [3:0] q, input logic [3:0] ch);
        exp_t e;
        e.c = c;
        e.q = q;
        e.ch = ch;
        sb.push_back(e);
    endtask

    initial begin
        #1 RST_N = 1'b0;
        #1;
        chk("rst_q", LED_Q, 4'b0000);
        chk("rst_nq", LED_NQ, 4'b1111);
        chk("rst_chg", CHANGED, 4'b0000);
        chk("rst_init_q", sd_q, 4'b1010);
        chk("rst_init_nq", sd_nq, 4'b0101);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #2 chk("post_rst_q", LED_Q, 4'b0000);

        drive(4'b0001, 4'b0000);
        repeat (DB ? 4 : 1) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("midcnt_rst_q", LED_Q, 4'b0000);
        chk("midcnt_rst_chg", CHANGED, 4'b0000);
        repeat (3) @(posedge CLK);
        #2 chk("in_rst_q", LED_Q, 4'b0000);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        push(cyc + 1 + L, 4'b0001, 4'b0001);
        repeat (L - 1) @(posedge CLK);
        #2 chk("before_set_q", LED_Q, 4'b0000);
        repeat (3) @(posedge CLK);
        #2 chk("set_q", LED_Q, 4'b0001);
        chk("set_nq", LED_NQ, 4'b1110);

        drive(4'b0000, 4'b0000);
        drive(4'b0010, 4'b0000);
        push(cyc + 1 + L, 4'b0011, 4'b0010);
        repeat (L + 2) @(posedge CLK);
        drive(4'b0000, 4'b0000);
        repeat (L + 2) @(posedge CLK);
        #2 chk("set1_q", LED_Q, 4'b0011);

        drive(4'b0000, 4'b0010);
        if (!DB) push(cyc + 1 + L, 4'b0001, 4'b0010);
        repeat (2) @(posedge CLK);
        drive(4'b0000, 4'b0000);
        repeat (10) @(posedge CLK);
        #2 chk("glitch3_q", LED_Q, DB ? 4'b0011 : 4'b0001);

        drive(4'b0000, 4'b0010);
        if (DB) push(cyc + 1 + L, 4'b0001, 4'b0010);
        repeat (4) @(posedge CLK);
        drive(4'b0000, 4'b0000);
        repeat (12) @(posedge CLK);
        #2 chk("glitch5_q", LED_Q, 4'b0001);

        drive(4'b0100, 4'b0100);
        repeat (L + 3) @(posedge CLK);
        #2 chk("dom_clr_q", LED_Q, 4'b0001);
        chk("dom_set_q2", {3'b000, sd_q[2]}, 4'b0001);
        drive(4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(posedge CLK);
            #2 chk("hold_q", LED_Q, 4'b0001);
        end

        drive(4'b1000, 4'b0001);
        push(cyc + 1 + L, 4'b1000, 4'b1001);
        repeat (L + 3) @(posedge CLK);
        #2 chk("par_q", LED_Q, 4'b1000);
        chk("par_nq", LED_NQ, 4'b0111);
        drive(4'b0000, 4'b0000);
        repeat (L + 2) @(posedge CLK);

        drive(4'b0100, 4'b0000);
        if (!DB) push(cyc + 1 + 2, 4'b1100, 4'b0100);
        drive(4'b0000, 4'b0000);
        repeat (12) @(posedge CLK);
        #2 chk("pulse_q", LED_Q, DB ? 4'b1000 : 4'b1100);

        repeat (5) @(posedge CLK);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL missing_pulses: got %0d outstanding want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
